mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/mem_arbiter_starve_counter.sv | 39 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch / load-store memory arbiter:
// FSM state codes, funct3 access-mode constants and a store-mode check.
package mem_arbiter_pkg;

    typedef logic [2:0] funct3_t;

    // Arbiter FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_LS = 2'd2;

    // RISC-V funct3 access modes the arbiter cares about
    localparam funct3_t F3_LW = 3'b010;
    localparam funct3_t F3_SB = 3'b000;
    localparam funct3_t F3_SH = 3'b001;
    localparam funct3_t F3_SW = 3'b010;

    // Stores are only forwarded to memory for byte/half/word widths
    function automatic logic store_mode_legal(input funct3_t mode);
        return (mode == F3_SB) || (mode == F3_SH) || (mode == F3_SW);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester- and memory-side signals of mem_arbiter.
// slave is the arbiter's view, master the view of requesters plus memory.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    funct3_t           ls_mode_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;
    logic              ls_err_o;

    logic              mem_re_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    funct3_t           mem_mode_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  clk,
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_mode_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_mode_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        input  clk,
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_mode_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_mode_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Counts consecutive arbitration losses of the fetch port; once the count
// reaches LIMIT the arbiter lets fetch win the next contested grant.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_lose_i,   // fetch was requesting and load/store got the grant
    input  logic if_win_i,    // fetch got the grant
    output logic at_limit_o
);
    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear on a fetch win, saturating increment on a fetch loss
    always_comb begin
        cnt_d = cnt_q;
        if (if_win_i) begin
            cnt_d = '0;
        end else if (if_lose_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a load/store port
// share one memory. One transaction is in flight at a time; load/store has
// priority unless fetch has lost STARVE_LIMIT contested grants in a row.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  funct3_t           ls_mode_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_err_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output funct3_t           mem_mode_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              we_q,        we_d;
    funct3_t           mode_q,      mode_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] ls_rdata_q,  ls_rdata_d;
    logic              ls_err_q,    ls_err_d;

    logic starve_full;
    logic grant_if;
    logic grant_ls;

    // Arbitration only happens in IDLE; grants are suppressed in a reset cycle
    always_comb begin
        grant_ls = (state_q == ST_IDLE) && !rst_i && ls_req_i && !(if_req_i && starve_full);
        grant_if = (state_q == ST_IDLE) && !rst_i && if_req_i && !grant_ls;
    end

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_lose_i  (grant_ls && if_req_i),
        .if_win_i   (grant_if),
        .at_limit_o (starve_full)
    );

    // Next-state, payload latching and response generation
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        mode_d      = mode_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        ls_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_if) begin
                    state_d = ST_BUSY_IF;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    mode_d  = F3_LW;
                end else if (grant_ls) begin
                    if (ls_we_i && !store_mode_legal(ls_mode_i)) begin
                        // Bad store width: answer with an error, never touch memory
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = '0;
                        ls_err_d    = 1'b1;
                    end else begin
                        state_d = ST_BUSY_LS;
                        addr_d  = ls_addr_i;
                        wdata_d = ls_wdata_i;
                        we_d    = ls_we_i;
                        mode_d  = ls_mode_i;
                    end
                end
            end
            ST_BUSY_IF: begin
                if (mem_ack_i) begin
                    state_d     = ST_IDLE;
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = mem_rdata_i;
                end
            end
            ST_BUSY_LS: begin
                if (mem_ack_i) begin
                    state_d     = ST_IDLE;
                    ls_rvalid_d = 1'b1;
                    ls_rdata_d  = we_q ? '0 : mem_rdata_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            mode_q      <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            mode_q      <= mode_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
        end
    end

    assign if_gnt_o    = grant_if;
    assign ls_gnt_o    = grant_ls;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign ls_err_o    = ls_err_q;

    // Memory strobes only while a transaction owns the bus
    assign mem_re_o    = (state_q == ST_BUSY_IF) || ((state_q == ST_BUSY_LS) && !we_q);
    assign mem_we_o    = (state_q == ST_BUSY_LS) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_mode_o  = mode_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: requester drivers and a
// memory responder run freely; a monitor predicts grants, strobes and
// responses from the arbitration rules and checks every DUT output event.
module tb_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    typedef struct { int unsigned gap; logic [AW-1:0] addr; } if_item_t;
    typedef struct { int unsigned gap; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [2:0] mode; } ls_item_t;
    typedef struct { logic [DW-1:0] rdata; logic err; } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    if_item_t if_todo[$];
    ls_item_t ls_todo[$];
    rsp_t     if_exp[$];
    rsp_t     ls_exp[$];
    logic if_active = 1'b0;
    logic ls_active = 1'b0;
    logic model_busy = 1'b0;
    logic exp_if_rv = 1'b0;
    logic exp_ls_rv = 1'b0;
    int mem_mode = 0;   // 0 random delay, 1 fixed delay, 2 never ack
    int fixed_dly = 0;
    int ack_req = 0;    // bumped by the main sequence to request one stray ack

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus (.clk(clk));

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(bus.if_req_i), .if_addr_i(bus.if_addr_i), .if_gnt_o(bus.if_gnt_o),
        .if_rvalid_o(bus.if_rvalid_o), .if_rdata_o(bus.if_rdata_o),
        .ls_req_i(bus.ls_req_i), .ls_we_i(bus.ls_we_i), .ls_addr_i(bus.ls_addr_i),
        .ls_wdata_i(bus.ls_wdata_i), .ls_mode_i(bus.ls_mode_i), .ls_gnt_o(bus.ls_gnt_o),
        .ls_rvalid_o(bus.ls_rvalid_o), .ls_rdata_o(bus.ls_rdata_o), .ls_err_o(bus.ls_err_o),
        .mem_re_o(bus.mem_re_o), .mem_we_o(bus.mem_we_o), .mem_addr_o(bus.mem_addr_o),
        .mem_wdata_o(bus.mem_wdata_o), .mem_mode_o(bus.mem_mode_o),
        .mem_ack_i(bus.mem_ack_i), .mem_rdata_i(bus.mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1357};
    endfunction

    function automatic logic legal_store(input logic [2:0] m);
        return (m == 3'b000) || (m == 3'b001) || (m == 3'b010);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fetch requester: hold request and address until granted
    initial begin
        if_item_t t;
        int n;
        bus.if_req_i = 1'b0;
        bus.if_addr_i = '0;
        @(posedge clk); #1;
        forever begin
            if (if_todo.size() == 0) begin
                bus.if_req_i = 1'b0;
                @(posedge clk); #1;
            end else begin
                t = if_todo.pop_front();
                if_active = 1'b1;
                bus.if_req_i = 1'b0;
                repeat (t.gap) begin @(posedge clk); #1; end
                bus.if_req_i = 1'b1;
                bus.if_addr_i = t.addr;
                n = 0;
                @(negedge clk);
                while (!bus.if_gnt_o && n < 500) begin @(negedge clk); n++; end
                if (n >= 500) chk("if_gnt_timeout", 64'(n), 0);
                if_active = 1'b0;
                @(posedge clk); #1;
            end
        end
    end

    // Load/store requester: hold request and payload until granted
    initial begin
        ls_item_t t;
        int n;
        bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_addr_i = '0;
        bus.ls_wdata_i = '0; bus.ls_mode_i = '0;
        @(posedge clk); #1;
        forever begin
            if (ls_todo.size() == 0) begin
                bus.ls_req_i = 1'b0;
                @(posedge clk); #1;
            end else begin
                t = ls_todo.pop_front();
                ls_active = 1'b1;
                bus.ls_req_i = 1'b0;
                repeat (t.gap) begin @(posedge clk); #1; end
                bus.ls_req_i = 1'b1;
                bus.ls_we_i = t.we; bus.ls_addr_i = t.addr;
                bus.ls_wdata_i = t.wdata; bus.ls_mode_i = t.mode;
                n = 0;
                @(negedge clk);
                while (!bus.ls_gnt_o && n < 500) begin @(negedge clk); n++; end
                if (n >= 500) chk("ls_gnt_timeout", 64'(n), 0);
                ls_active = 1'b0;
                @(posedge clk); #1;
            end
        end
    end

    // Memory responder: one-cycle ack after a configurable number of strobe cycles
    initial begin
        int dly = -1;
        int ack_done = 0;
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_ack_i) begin
                bus.mem_ack_i = 1'b0;
                dly = -1;
            end else if (ack_req != ack_done) begin
                ack_done++;
                bus.mem_ack_i = 1'b1;
                bus.mem_rdata_i = $urandom;
            end else if (mem_mode != 2 && (bus.mem_re_o || bus.mem_we_o)) begin
                if (dly < 0) dly = (mem_mode == 1) ? fixed_dly : int'($urandom_range(0, 3));
                if (dly == 0) begin
                    bus.mem_ack_i = 1'b1;
                    bus.mem_rdata_i = mem_data(bus.mem_addr_o);
                end else begin
                    dly--;
                end
            end else begin
                dly = -1;
            end
        end
    end

    // Monitor with reference model: one outstanding transaction, ls-first
    // priority with a starvation override, responses the cycle after ack
    initial begin
        int starve = 0;
        int owner = 0;   // 1 fetch, 2 load/store
        logic pw;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic [2:0] pm;
        logic e_if, e_ls, n_if_rv, n_ls_rv;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_busy = 1'b0; owner = 0; starve = 0;
                exp_if_rv = 1'b0; exp_ls_rv = 1'b0;
                if_exp.delete(); ls_exp.delete();
            end else begin
                if (exp_if_rv || bus.if_rvalid_o) begin
                    chk("if_rvalid", 64'(bus.if_rvalid_o), 64'(exp_if_rv));
                    if (exp_if_rv && bus.if_rvalid_o) begin
                        chk("if_scoreboard_nonempty", 64'(if_exp.size() != 0), 1);
                        if (if_exp.size() != 0) begin
                            r = if_exp.pop_front();
                            chk("if_rdata", 64'(bus.if_rdata_o), 64'(r.rdata));
                        end
                    end
                end
                if (exp_ls_rv || bus.ls_rvalid_o) begin
                    chk("ls_rvalid", 64'(bus.ls_rvalid_o), 64'(exp_ls_rv));
                    if (exp_ls_rv && bus.ls_rvalid_o) begin
                        chk("ls_scoreboard_nonempty", 64'(ls_exp.size() != 0), 1);
                        if (ls_exp.size() != 0) begin
                            r = ls_exp.pop_front();
                            chk("ls_rdata", 64'(bus.ls_rdata_o), 64'(r.rdata));
                            chk("ls_err", 64'(bus.ls_err_o), 64'(r.err));
                        end
                    end
                end
                if (model_busy) begin
                    chk("mem_re", 64'(bus.mem_re_o), 64'(!pw));
                    chk("mem_we", 64'(bus.mem_we_o), 64'(pw));
                    chk("mem_addr", 64'(bus.mem_addr_o), 64'(pa));
                    chk("mem_mode", 64'(bus.mem_mode_o), 64'(pm));
                    if (owner == 2) chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(pd));
                end else begin
                    chk("idle_strobes", 64'({bus.mem_re_o, bus.mem_we_o}), 0);
                end
                e_ls = !model_busy && bus.ls_req_i && !(bus.if_req_i && starve == LIMIT);
                e_if = !model_busy && bus.if_req_i && !e_ls;
                if (e_if || e_ls || bus.if_gnt_o || bus.ls_gnt_o)
                    chk("gnt_if_ls", 64'({bus.if_gnt_o, bus.ls_gnt_o}), 64'({e_if, e_ls}));
                n_if_rv = 1'b0;
                n_ls_rv = 1'b0;
                if (model_busy && bus.mem_ack_i) begin
                    if (owner == 1) n_if_rv = 1'b1; else n_ls_rv = 1'b1;
                    model_busy = 1'b0;
                    owner = 0;
                end
                if (e_if) begin
                    starve = 0;
                    if_exp.push_back('{mem_data(bus.if_addr_i), 1'b0});
                    model_busy = 1'b1; owner = 1;
                    pw = 1'b0; pa = bus.if_addr_i; pd = '0; pm = 3'b010;
                end else if (e_ls) begin
                    if (bus.if_req_i && starve < LIMIT) starve++;
                    if (bus.ls_we_i && !legal_store(bus.ls_mode_i)) begin
                        ls_exp.push_back('{'0, 1'b1});
                        n_ls_rv = 1'b1;
                    end else begin
                        ls_exp.push_back('{bus.ls_we_i ? '0 : mem_data(bus.ls_addr_i), 1'b0});
                        model_busy = 1'b1; owner = 2;
                        pw = bus.ls_we_i; pa = bus.ls_addr_i; pd = bus.ls_wdata_i; pm = bus.ls_mode_i;
                    end
                end
                exp_if_rv = n_if_rv;
                exp_ls_rv = n_ls_rv;
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((if_todo.size() != 0 || ls_todo.size() != 0 || if_active || ls_active ||
                model_busy || exp_if_rv || exp_ls_rv) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 64'(n), 0);
        repeat (2) @(negedge clk);
    endtask

    // Main sequence: reset, directed scenarios, random traffic, mid-transaction reset
    initial begin
        logic [2:0] st_modes [5];
        logic [2:0] ld_modes [5];
        int n;
        st_modes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
        ld_modes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", 64'(bus.if_gnt_o), 0);
        chk("rst_ls_gnt", 64'(bus.ls_gnt_o), 0);
        chk("rst_if_rvalid", 64'(bus.if_rvalid_o), 0);
        chk("rst_ls_rvalid", 64'(bus.ls_rvalid_o), 0);
        chk("rst_ls_err", 64'(bus.ls_err_o), 0);
        chk("rst_mem_re", 64'(bus.mem_re_o), 0);
        chk("rst_mem_we", 64'(bus.mem_we_o), 0);
        chk("rst_if_rdata", 64'(bus.if_rdata_o), 0);
        chk("rst_ls_rdata", 64'(bus.ls_rdata_o), 0);
        chk("rst_mem_addr", 64'(bus.mem_addr_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        // Single fetch, ack in the first strobe cycle
        mem_mode = 1; fixed_dly = 0;
        if_todo.push_back('{0, 32'h100});
        wait_drain();
        $display("[directed] single fetch 0x100 done");

        // Simultaneous fetch and load to the same address
        ls_todo.push_back('{0, 1'b0, 32'h200, 32'h0, 3'b010});
        if_todo.push_back('{0, 32'h200});
        wait_drain();
        $display("[directed] simultaneous if/ls 0x200 done");

        // Continuous load/store pressure against a waiting fetch
        for (int i = 0; i < 6; i++) ls_todo.push_back('{0, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 3'b010});
        for (int i = 0; i < 2; i++) if_todo.push_back('{0, 32'h400 + 32'(4 * i)});
        wait_drain();
        $display("[directed] starvation sequence done");

        // Half-word store with a slow memory
        fixed_dly = 3;
        ls_todo.push_back('{0, 1'b1, 32'h10, 32'h1234, 3'b001});
        wait_drain();
        $display("[directed] SH store with delayed ack done");

        // Store with an unsupported width
        fixed_dly = 0;
        ls_todo.push_back('{0, 1'b1, 32'h20, 32'hCAFE, 3'b011});
        wait_drain();
        $display("[directed] illegal store mode done");

        // Random traffic on both ports with random memory latency
        mem_mode = 0;
        for (int i = 0; i < 40; i++) begin
            if_todo.push_back('{$urandom_range(0, 4), $urandom & 32'h0000_FFFC});
            if ($urandom_range(0, 1) == 1)
                ls_todo.push_back('{$urandom_range(0, 4), 1'b1, $urandom & 32'h0000_FFFF, $urandom,
                                    st_modes[$urandom_range(0, 4)]});
            else
                ls_todo.push_back('{$urandom_range(0, 4), 1'b0, $urandom & 32'h0000_FFFF, 32'h0,
                                    ld_modes[$urandom_range(0, 4)]});
        end
        wait_drain();
        $display("[random] 80 transactions done");

        // Reset while a store waits for an ack that never comes, then a stray ack
        mem_mode = 2;
        ls_todo.push_back('{0, 1'b1, 32'h40, 32'h5555_AAAA, 3'b010});
        n = 0;
        while ((ls_todo.size() != 0 || ls_active) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("busy_ls_timeout", 64'(n), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        ack_req++;
        repeat (4) @(negedge clk);
        chk("post_rst_ls_rdata", 64'(bus.ls_rdata_o), 0);
        chk("post_rst_if_rdata", 64'(bus.if_rdata_o), 0);
        chk("post_rst_mem_we", 64'(bus.mem_we_o), 0);
        $display("[directed] reset in BUSY_LS with late ack done");

        mem_mode = 0;
        ls_todo.push_back('{0, 1'b0, 32'h44, 32'h0, 3'b010});
        if_todo.push_back('{1, 32'h48});
        wait_drain();
        $display("[directed] traffic after reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
